// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes plus the command sequencer's
// command bytes and FSM state encoding.
package alu_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int OUT_WIDTH  = 16;

  localparam logic [7:0] CMD_ALU_OPER = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP  = 8'hDD;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_MUL   = 4'd2,
    ALU_DIV   = 4'd3,
    ALU_AND   = 4'd4,
    ALU_OR    = 4'd5,
    ALU_NAND  = 4'd6,
    ALU_NOR   = 4'd7,
    ALU_XOR   = 4'd8,
    ALU_XNOR  = 4'd9,
    ALU_CMPEQ = 4'd10,
    ALU_CMPGT = 4'd11,
    ALU_CMPLT = 4'd12,
    ALU_SHR   = 4'd13,
    ALU_SHL   = 4'd14
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_A    = 3'd1,
    ST_GET_B    = 3'd2,
    ST_GET_FUN  = 3'd3,
    ST_ALU_EXEC = 3'd4,
    ST_ALU_WAIT = 3'd5,
    ST_TX_LO    = 3'd6,
    ST_TX_HI    = 3'd7
  } ctrl_state_e;

endpackage

// File: rtl/alu_cmd_ctrl.sv
// Command sequencer between UART RX/TX and the ALU: parses command frames,
// fires the ALU once per frame and returns the result low byte first.
module alu_cmd_ctrl
  import alu_pkg::*;
#(
  parameter int                    DATA_WIDTH   = alu_pkg::DATA_WIDTH,
  parameter int                    OUT_WIDTH    = alu_pkg::OUT_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_OPER = alu_pkg::CMD_ALU_OPER,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP  = alu_pkg::CMD_ALU_NOP
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic                  RX_VALID,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output alu_op_e               ALU_FUN,
  output logic                  ALU_EN,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VALID,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  BUSY,
  output logic                  RX_DROP,
  output ctrl_state_e           dbg_state
);

  // TX handshake: a byte transfers on a cycle where TX_VALID && TX_READY;
  // while TX_READY is low, TX_VALID and TX_DATA are held unchanged.

  ctrl_state_e          state;
  logic [OUT_WIDTH-1:0] result;

  assign dbg_state = state;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      ALU_A    <= '0;
      ALU_B    <= '0;
      ALU_FUN  <= ALU_ADD;
      ALU_EN   <= 1'b0;
      TX_DATA  <= '0;
      TX_VALID <= 1'b0;
      BUSY     <= 1'b0;
      RX_DROP  <= 1'b0;
      result   <= '0;
    end else begin
      ALU_EN  <= 1'b0;
      RX_DROP <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (RX_VALID) begin
            if (RX_DATA == CMD_ALU_OPER) begin
              state <= ST_GET_A;
              BUSY  <= 1'b1;
            end else if (RX_DATA == CMD_ALU_NOP) begin
              state <= ST_GET_FUN;
              BUSY  <= 1'b1;
            end else begin
              RX_DROP <= 1'b1;
            end
          end
        end
        ST_GET_A: begin
          if (RX_VALID) begin
            ALU_A <= RX_DATA;
            state <= ST_GET_B;
          end
        end
        ST_GET_B: begin
          if (RX_VALID) begin
            ALU_B <= RX_DATA;
            state <= ST_GET_FUN;
          end
        end
        ST_GET_FUN: begin
          if (RX_VALID) begin
            ALU_FUN <= alu_op_e'(RX_DATA[3:0]);
            ALU_EN  <= 1'b1;
            state   <= ST_ALU_EXEC;
          end
        end
        ST_ALU_EXEC: begin
          RX_DROP <= RX_VALID;
          state   <= ST_ALU_WAIT;
        end
        ST_ALU_WAIT: begin
          RX_DROP <= RX_VALID;
          if (ALU_OUT_VALID) begin
            result   <= ALU_OUT;
            TX_DATA  <= ALU_OUT[DATA_WIDTH-1:0];
            TX_VALID <= 1'b1;
            state    <= ST_TX_LO;
          end
        end
        ST_TX_LO: begin
          RX_DROP <= RX_VALID;
          if (TX_READY) begin
            TX_DATA <= result[OUT_WIDTH-1:DATA_WIDTH];
            state   <= ST_TX_HI;
          end else begin
            TX_DATA <= result[DATA_WIDTH-1:0];
          end
        end
        ST_TX_HI: begin
          RX_DROP <= RX_VALID;
          if (TX_READY) begin
            TX_VALID <= 1'b0;
            BUSY     <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          TX_VALID <= 1'b0;
          BUSY     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Randomized scoreboard bench for alu_cmd_ctrl with a behavioural ALU stub
// and a frame-level model of operands, results and dropped bytes.
module tb_alu_cmd_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  alu_a, alu_b;
  alu_op_e     alu_fun;
  logic        alu_en;
  logic [15:0] alu_out;
  logic        alu_out_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy, rx_drop;
  ctrl_state_e dbg_state;

  always #5 clk = ~clk;

  alu_cmd_ctrl dut (
    .CLK(clk), .RST(rst), .RX_DATA(rx_data), .RX_VALID(rx_valid),
    .ALU_A(alu_a), .ALU_B(alu_b), .ALU_FUN(alu_fun), .ALU_EN(alu_en),
    .ALU_OUT(alu_out), .ALU_OUT_VALID(alu_out_valid),
    .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready),
    .BUSY(busy), .RX_DROP(rx_drop), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0]  exp_q[$];
  logic [19:0] exp_op_q[$];
  int exp_drops = 0;
  int seen_drops = 0;
  logic [7:0] m_a = '0;
  logic [7:0] m_b = '0;
  logic hold_ready = 1'b0;

  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] f);
    logic [15:0] wa, wb;
    wa = {8'h00, a};
    wb = {8'h00, b};
    case (f)
      4'd0:  return wa + wb;
      4'd1:  return wa - wb;
      4'd2:  return wa * wb;
      4'd3:  return (b == 8'h00) ? 16'h0000 : wa / wb;
      4'd4:  return wa & wb;
      4'd5:  return wa | wb;
      4'd6:  return {8'h00, ~(a & b)};
      4'd7:  return {8'h00, ~(a | b)};
      4'd8:  return wa ^ wb;
      4'd9:  return {8'h00, ~(a ^ b)};
      4'd10: return (a == b) ? 16'd1 : 16'd0;
      4'd11: return (a > b) ? 16'd1 : 16'd0;
      4'd12: return (a < b) ? 16'd1 : 16'd0;
      4'd13: return wa >> 1;
      4'd14: return wa << 1;
      default: return 16'h0000;
    endcase
  endfunction

  // ALU stub: result valid two edges after ALU_EN is sampled
  logic s1;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      alu_out_valid <= 1'b0;
      alu_out <= '0;
    end else begin
      s1 <= alu_en;
      alu_out_valid <= s1;
      if (s1) alu_out <= alu_ref(alu_a, alu_b, alu_fun);
    end
  end

  always @(posedge clk) begin
    #2;
    tx_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: ALU issue, TX stream, stall stability and drop pulses
  logic prev_en = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_en = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (alu_en) begin
        if (exp_op_q.size() == 0) check("alu_en_unexpected", 1, 0);
        else check("alu_operands", {alu_a, alu_b, alu_fun}, exp_op_q.pop_front());
        if (prev_en) check("alu_en_width", 2, 1);
      end
      prev_en = alu_en;
      if (rx_drop) seen_drops++;
      if (prev_stall) begin
        check("tx_valid_hold", tx_valid, 1);
        check("tx_data_hold", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) check("tx_unexpected", tx_data, 32'hFFFF);
        else check("tx_byte", tx_data, exp_q.pop_front());
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data = tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic exp_drop);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("rx_drop", rx_drop, exp_drop);
    if (exp_drop) exp_drops++;
  endtask

  task automatic send_frame(input logic oper, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] f);
    logic [15:0] r;
    if (oper) begin
      send_byte(CMD_ALU_OPER, 1'b0);
      send_byte(a, 1'b0);
      send_byte(b, 1'b0);
      m_a = a;
      m_b = b;
    end else begin
      send_byte(CMD_ALU_NOP, 1'b0);
    end
    r = alu_ref(m_a, m_b, f[3:0]);
    exp_op_q.push_back({m_a, m_b, f[3:0]});
    exp_q.push_back(r[7:0]);
    exp_q.push_back(r[15:8]);
    send_byte(f, 1'b0);
    check("alu_en_latency", alu_en, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", (n >= 300), 0);
    check("busy_after_frame", busy, 0);
  endtask

  task automatic wait_tx_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tx_valid_timeout", (n >= 100), 0);
  endtask

  initial begin
    #1;
    check("rst_alu_a", alu_a, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    send_frame(1'b1, 8'h05, 8'h03, 8'h00);
    wait_idle();
    send_frame(1'b1, 8'hFF, 8'hFF, 8'h02);
    wait_idle();
    send_frame(1'b0, 8'h00, 8'h00, 8'h01);
    wait_idle();

    // Junk in IDLE, then back-pressure and a junk byte while in TX_LO
    send_byte(8'h7E, 1'b1);
    hold_ready = 1'b1;
    send_frame(1'b1, 8'h12, 8'h34, 8'hA0);
    wait_tx_valid();
    send_byte(8'h55, 1'b1);
    repeat (4) @(negedge clk);
    hold_ready = 1'b0;
    wait_idle();

    // Reset mid-frame abandons it and clears the operands
    send_byte(CMD_ALU_OPER, 1'b0);
    send_byte(8'h05, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_alu_a", alu_a, 0);
    check("midrst_busy", busy, 0);
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_alu_en", alu_en, 0);
    check("midrst_rx_drop", rx_drop, 0);
    m_a = '0;
    m_b = '0;
    @(negedge clk);
    rst = 1'b1;
    send_frame(1'b0, 8'h00, 8'h00, 8'h00);
    wait_idle();
    send_frame(1'b1, 8'h02, 8'h02, 8'h00);
    wait_idle();

    for (int i = 0; i < 25; i++) begin
      logic [7:0] junk;
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == CMD_ALU_OPER || junk == CMD_ALU_NOP) junk = 8'h00;
        send_byte(junk, 1'b1);
      end
      send_frame(($urandom_range(0, 2) != 0), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait_idle();
    end

    repeat (5) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    check("exp_op_q_empty", exp_op_q.size(), 0);
    check("drop_count", seen_drops, exp_drops);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
